// File: rtl/frogger_pkg.sv
// ============================================================================
// Module      : frogger_pkg
// Description : Shared screen geometry, lane constants, car reset layout and
//               traffic FSM encoding for the frogger video pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package frogger_pkg;

  localparam int unsigned H_VISIBLE_AREA = 640;
  localparam int unsigned V_VISIBLE_AREA = 480;
  localparam int unsigned TILE_SIZE      = 32;
  localparam int unsigned BASE_PERIOD    = 8;

  localparam logic [9:0] C_LINE_1_Y = 10'd96;
  localparam logic [9:0] C_LINE_2_Y = 10'd160;
  localparam logic [9:0] C_LINE_3_Y = 10'd224;
  localparam logic [9:0] C_LINE_4_Y = 10'd288;

  // Index 0 is car 1 ... index 5 is car 6
  localparam logic [5:0][9:0] C_CAR_RESET_X = {10'd480, 10'd320, 10'd480,
                                               10'd320, 10'd160, 10'd0};
  localparam logic [3:0] C_REVERSE_RESET = 4'b0101;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LANE0  = 3'd1,
    ST_LANE1  = 3'd2,
    ST_LANE2  = 3'd3,
    ST_LANE3  = 3'd4,
    ST_COMMIT = 3'd5
  } state_e;

  // Cars 1/5 share lane 0 and cars 2/6 share lane 1
  function automatic logic [1:0] car_lane(input int car);
    case (car)
      0, 4:    return 2'd0;
      1, 5:    return 2'd1;
      2:       return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  function automatic logic [3:0] level_to_period(input logic [2:0] level);
    if ({1'b0, level} >= 4'(BASE_PERIOD - 1)) return 4'd1;
    return 4'(BASE_PERIOD) - {1'b0, level};
  endfunction

endpackage

`default_nettype wire

// File: rtl/car_lane_stepper.sv
// ============================================================================
// Module      : car_lane_stepper
// Description : Divider compare, next-X arithmetic and edge flip decision for
//               one car. Define CAR_BOUNCE_EN for bounce, otherwise wrap.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module car_lane_stepper
  import frogger_pkg::*;
(
  input  logic [3:0] i_Div,
  input  logic [3:0] i_Period,
  input  logic [9:0] i_X,
  input  logic       i_Forward,
  input  logic [2:0] i_Step,
  output logic       o_Fire,
  output logic [9:0] o_Next_X,
  output logic       o_Flip
);

  logic [10:0] w_x_ext;
  logic [10:0] w_step_ext;
  logic [10:0] w_sum;

  assign w_x_ext    = {1'b0, i_X};
  assign w_step_ext = {8'd0, i_Step};
  assign w_sum      = w_x_ext + w_step_ext;
  assign o_Fire     = (i_Div >= (i_Period - 4'd1));

`ifdef CAR_BOUNCE_EN
  localparam logic [10:0] C_X_LIMIT = 11'(H_VISIBLE_AREA - TILE_SIZE);

  always_comb begin
    o_Next_X = i_X;
    o_Flip   = 1'b0;
    if (i_Forward) begin
      if (w_sum > C_X_LIMIT) begin
        o_Next_X = 10'(C_X_LIMIT);
        o_Flip   = 1'b1;
      end else begin
        o_Next_X = 10'(w_sum);
      end
    end else begin
      if (w_x_ext < w_step_ext) begin
        o_Next_X = 10'd0;
        o_Flip   = 1'b1;
      end else begin
        o_Next_X = 10'(w_x_ext - w_step_ext);
      end
    end
  end
`else
  localparam logic [10:0] C_H_VIS_11 = 11'(H_VISIBLE_AREA);

  always_comb begin
    o_Next_X = i_X;
    o_Flip   = 1'b0;
    if (i_Forward) begin
      if (w_sum >= C_H_VIS_11) o_Next_X = 10'(w_sum - C_H_VIS_11);
      else                     o_Next_X = 10'(w_sum);
    end else begin
      if (w_x_ext < w_step_ext) o_Next_X = 10'(w_x_ext + C_H_VIS_11 - w_step_ext);
      else                      o_Next_X = 10'(w_x_ext - w_step_ext);
    end
  end
`endif

endmodule

`default_nettype wire

// File: rtl/car_traffic_controller.sv
// ============================================================================
// Module      : car_traffic_controller
// Description : Per-frame car position sequencer with double-buffered outputs.
//               CAR_BOUNCE_EN selects bouncing cars instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module car_traffic_controller
  import frogger_pkg::*;
(
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic [9:0] i_H_Counter,
  input  logic [9:0] i_V_Counter,
  input  logic       i_Run,
  input  logic [2:0] i_Level,
  output logic [9:0] o_Car_1X_Position,
  output logic [9:0] o_Car_2X_Position,
  output logic [9:0] o_Car_3X_Position,
  output logic [9:0] o_Car_4X_Position,
  output logic [9:0] o_Car_5X_Position,
  output logic [9:0] o_Car_6X_Position,
  output logic [3:0] o_Reverse,
  output logic       o_Busy,
  output logic       o_Frame_Done
);

  state_e           state_q, state_d;
  logic [3:0]       period_q, period_d;
  logic [3:0][3:0]  div_q, div_d;
  logic [5:0][9:0]  shadow_q, shadow_d;
  logic [5:0][9:0]  out_q, out_d;
  logic [3:0]       rev_q, rev_d;
  logic [3:0]       rev_out_q, rev_out_d;
  logic             done_q, done_d;

  logic             w_tick;
  logic [5:0]       w_fire;
  logic [5:0]       w_flip;
  logic [5:0][9:0]  w_next_x;
  logic [1:0]       w_lane;
  logic             w_lane_flip;

  assign w_tick = (i_V_Counter == 10'(V_VISIBLE_AREA)) && (i_H_Counter == 10'd0);

  for (genvar gi = 0; gi < 6; gi++) begin : g_car
    localparam logic [1:0] LANE = car_lane(gi);
    car_lane_stepper u_stepper (
      .i_Div     (div_q[LANE]),
      .i_Period  (period_q),
      .i_X       (shadow_q[gi]),
      .i_Forward (rev_q[LANE]),
      .i_Step    (3'(LANE) + 3'd1),
      .o_Fire    (w_fire[gi]),
      .o_Next_X  (w_next_x[gi]),
      .o_Flip    (w_flip[gi])
    );
  end

  always_comb begin
    state_d     = state_q;
    period_d    = period_q;
    div_d       = div_q;
    shadow_d    = shadow_q;
    out_d       = out_q;
    rev_d       = rev_q;
    rev_out_d   = rev_out_q;
    done_d      = 1'b0;
    w_lane      = 2'(state_q - ST_LANE0);
    w_lane_flip = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (w_tick && i_Run) begin
          state_d  = ST_LANE0;
          period_d = level_to_period(i_Level);
        end
      end
      ST_LANE0, ST_LANE1, ST_LANE2, ST_LANE3: begin
        if (w_fire[w_lane]) div_d[w_lane] = 4'd0;
        else                div_d[w_lane] = div_q[w_lane] + 4'd1;
        // Both cars of a lane move together; either hitting an edge flips the lane
        for (int c = 0; c < 6; c++) begin
          if ((car_lane(c) == w_lane) && w_fire[c]) begin
            shadow_d[c] = w_next_x[c];
            w_lane_flip = w_lane_flip | w_flip[c];
          end
        end
        rev_d[w_lane] = rev_q[w_lane] ^ w_lane_flip;
        state_d       = state_e'(state_q + 3'd1);
      end
      ST_COMMIT: begin
        out_d     = shadow_q;
        rev_out_d = rev_q;
        done_d    = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q   <= ST_IDLE;
      period_q  <= 4'(BASE_PERIOD);
      div_q     <= '0;
      shadow_q  <= C_CAR_RESET_X;
      out_q     <= C_CAR_RESET_X;
      rev_q     <= C_REVERSE_RESET;
      rev_out_q <= C_REVERSE_RESET;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      period_q  <= period_d;
      div_q     <= div_d;
      shadow_q  <= shadow_d;
      out_q     <= out_d;
      rev_q     <= rev_d;
      rev_out_q <= rev_out_d;
      done_q    <= done_d;
    end
  end

  assign o_Car_1X_Position = out_q[0];
  assign o_Car_2X_Position = out_q[1];
  assign o_Car_3X_Position = out_q[2];
  assign o_Car_4X_Position = out_q[3];
  assign o_Car_5X_Position = out_q[4];
  assign o_Car_6X_Position = out_q[5];
  assign o_Reverse         = rev_out_q;
  assign o_Busy            = (state_q != ST_IDLE);
  assign o_Frame_Done      = done_q;

endmodule

`default_nettype wire

// File: doc/car_traffic_controller.md
# car_traffic_controller

Sequences the car sprites drawn by the sprite display stage. Once per video frame, during vertical blanking, it advances the six car X positions and the four lane direction flags. It owns per-lane speed dividers, screen-edge handling and double-buffered position outputs, so the display pipeline never sees a position change mid-frame. It sits between the game-state logic (run/level inputs) and the sprite display block, whose car position and reverse inputs it drives directly.

## Interface
- H_VISIBLE_AREA, 640, visible width; X positions live in 0..H_VISIBLE_AREA-1
- V_VISIBLE_AREA, 480, first blanking line; frame tick line
- TILE_SIZE, 32, car sprite width (used only under CAR_BOUNCE_EN)
- BASE_PERIOD, 8, frames per lane step at level 0 (4-bit)
- i_Clk  in  1  system/pixel clock, single clock domain
- i_Reset  in  1  synchronous, active-high reset
- i_H_Counter  in  10  horizontal scan counter
- i_V_Counter  in  10  vertical scan counter
- i_Run  in  1  1 = cars move; 0 = freeze positions and dividers
- i_Level  in  3  difficulty; sampled at frame tick
- o_Car_1X_Position … o_Car_6X_Position  out  10 each  car X; cars 1/5 on lane 0, 2/6 on lane 1, 3 on lane 2, 4 on lane 3
- o_Reverse  out  4  per-lane flag; 1 = lane moves toward increasing X
- o_Busy  out  1  high while the update FSM is not IDLE
- o_Frame_Done  out  1  one-cycle pulse when new positions are committed

## Operation
- Frame tick: the cycle where i_V_Counter == V_VISIBLE_AREA and i_H_Counter == 0.
- FSM states:
  - IDLE → LANE0 on frame tick with i_Run=1. A tick with i_Run=0 stays in IDLE.
  - LANE0 → LANE1 → LANE2 → LANE3 → COMMIT → IDLE, one cycle each.
- i_Level is latched at the tick: period = BASE_PERIOD − i_Level, floored at 1.
- Per-lane frame divider:
  - In state LANEn, increment lane n's divider.
  - If the divider is at or above period−1, clear it and step the lane. Otherwise hold.
- Lane step: lane n moves n+1 pixels.
  - LANE0 updates cars 1 and 5 in the same cycle.
  - LANE1 updates cars 2 and 6 in the same cycle.
- Shadow registers hold the working positions. Output registers copy the shadows only in COMMIT.
- Wrap arithmetic (default build), done at 11 bits:
  - Forward: x' = x + s, minus H_VISIBLE_AREA if the sum is ≥ H_VISIBLE_AREA.
  - Backward: x' = x − s, plus H_VISIBLE_AREA if x < s.
  - Results always lie in 0..H_VISIBLE_AREA−1.
- Reset values:
  - Shadow and output positions: car1=0, car2=160, car3=320, car4=480, car5=320, car6=480.
  - o_Reverse = 4'b0101.
  - All dividers 0, state IDLE, o_Busy=0, o_Frame_Done=0.
- i_Reset during any state:
  - Returns the block to reset values on that edge.
  - Discards partial shadow updates.
  - No o_Frame_Done pulse is produced.
- A frame tick while not IDLE is ignored. It cannot occur with legal scan timing, but this is still required.
- i_Run falling mid-sequence: the sequence completes. i_Run is checked only at the tick.

## Timing
- Tick sampled at edge T.
- States LANE0..LANE3 occupy cycles T+1..T+4, and COMMIT occupies T+5.
- New outputs and o_Frame_Done=1 are visible after edge T+6.
- o_Frame_Done lasts exactly one cycle.
- o_Busy is high in cycles T+1..T+5.
- Total latency from tick to committed positions: 6 cycles, well inside vertical blanking.
- Outputs are registered, with no combinational path from any input.

## Configuration
- CAR_BOUNCE_EN defined:
  - Cars bounce instead of wrapping. The range is 0..H_VISIBLE_AREA−TILE_SIZE.
  - A forward step that would exceed the limit clamps to the limit and toggles o_Reverse[n].
  - A backward step that would go below 0 clamps to 0 and toggles o_Reverse[n].
  - The toggle is committed together with the positions.
  - Lanes 0/1: the flip applies if either car of the lane hits an edge. Both cars then clamp or move per the new direction from the next step.
- CAR_BOUNCE_EN undefined:
  - Wrap arithmetic as above.
  - o_Reverse is constant at its reset value.

## Structure
- Shared package frogger_pkg holds:
  - H_VISIBLE_AREA, V_VISIBLE_AREA, TILE_SIZE
  - lane Y constants C_LINE_1_Y..C_LINE_4_Y
  - car reset positions
  - reverse reset pattern 4'b0101
  - FSM state encoding
- One sub-module, car_lane_stepper, contains:
  - the divider compare
  - the next-X arithmetic (wrap or bounce)
  - the flip decision for one car
- The controller instantiates car_lane_stepper six times and keeps the FSM, dividers and shadow/output registers.

## Test plan
- Reset, then idle frames with i_Run=0 → positions 0/160/320/480/320/480, o_Reverse=0101, no o_Frame_Done.
- i_Run=1, i_Level=0, 8 frame ticks → exactly one step per lane on the 8th tick:
  - car1 0→1 (forward)
  - car2 160→158 (backward)
  - car3 320→323
  - car4 480→476
  - one o_Frame_Done pulse per tick, each at T+6
- i_Level=7 (period 1), car1 preset near edge via ticks → forward wrap, e.g. 639+1→0; car2 at 1 stepping backward by 2 → 639.
- Scan-counter sweep mid-frame → outputs change only at T+6 after the V=480/H=0 tick; o_Busy high for exactly 5 cycles.
- i_Reset asserted at T+3 → reset values on the next edge, no o_Frame_Done; the next tick resumes normally.
- CAR_BOUNCE_EN build, lane 3 stepping backward reaches 0 → clamps at 0, o_Reverse[3] 0→1 at commit, position increases on the following step.
